alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 121 ++++++++++++
 tb/tb_alu_result_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Two-entry in-order result buffer between the logic unit and writeback, with
// precomputed zero/negative flags and a saturating delivered-result counter.
// Optional per-entry parity (out_parity) is enabled by defining RESULT_PARITY_EN.
module alu_result_stage #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_res,
    input  logic [2:0]       in_funct,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_res,
    output logic [2:0]       out_funct,
    output logic             out_zero,
    output logic             out_neg,
`ifdef RESULT_PARITY_EN
    output logic             out_parity,
`endif
    output logic [CNT_W-1:0] res_count
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  funct;
        logic        zero;
        logic        neg;
`ifdef RESULT_PARITY_EN
        logic        parity;
`endif
    } entry_t;

    occ_e             occ_q, occ_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    entry_t           entry_q [2];
    entry_t           entry_d [2];
    logic [CNT_W-1:0] res_count_q, res_count_d;

    logic             push;
    logic             pop;
    entry_t           new_entry;
    entry_t           head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q       <= OCC_EMPTY;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            entry_q[0]  <= '0;
            entry_q[1]  <= '0;
            res_count_q <= '0;
        end else begin
            occ_q       <= occ_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            entry_q[0]  <= entry_d[0];
            entry_q[1]  <= entry_d[1];
            res_count_q <= res_count_d;
        end
    end

    always_comb begin
        in_ready  = (occ_q != OCC_FULL);
        out_valid = (occ_q != OCC_EMPTY);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;

        // Flags are captured with the entry so the head never needs a wide compare.
        new_entry        = '0;
        new_entry.res    = in_res;
        new_entry.funct  = in_funct;
        new_entry.zero   = (in_res == 32'd0);
        new_entry.neg    = in_res[31];
`ifdef RESULT_PARITY_EN
        new_entry.parity = ^in_res;
`endif

        occ_d = occ_q;
        unique case (occ_q)
            OCC_EMPTY: if (push) occ_d = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)      occ_d = OCC_FULL;
                else if (pop && !push) occ_d = OCC_EMPTY;
            end
            OCC_FULL:  if (pop) occ_d = OCC_ONE;
            default:   occ_d = OCC_EMPTY;
        endcase

        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;

        entry_d[0] = entry_q[0];
        entry_d[1] = entry_q[1];
        if (push) entry_d[wr_ptr_q] = new_entry;

        res_count_d = res_count_q;
        if (pop && (res_count_q != '1)) res_count_d = res_count_q + CNT_W'(1);

        head = '0;
        if (out_valid) head = entry_q[rd_ptr_q];
    end

    assign out_res    = head.res;
    assign out_funct  = head.funct;
    assign out_zero   = head.zero;
    assign out_neg    = head.neg;
`ifdef RESULT_PARITY_EN
    assign out_parity = head.parity;
`endif
    assign res_count  = res_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed vector table, reset/stream sequences and
// randomized traffic against a queue-based model; a CNT_W=4 copy checks saturation.
module tb_alu_result_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_res;
    logic [2:0]  in_funct;
    logic        out_ready;

    logic        in_ready, out_valid, out_zero, out_neg;
    logic [31:0] out_res;
    logic [2:0]  out_funct;
    logic [15:0] res_count;
    logic        in_ready4, out_valid4, out_zero4, out_neg4;
    logic [31:0] out_res4;
    logic [2:0]  out_funct4;
    logic [3:0]  res_count4;
`ifdef RESULT_PARITY_EN
    logic        out_parity, out_parity4;
`endif

    alu_result_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_res(in_res), .in_funct(in_funct), .out_valid(out_valid),
        .out_ready(out_ready), .out_res(out_res), .out_funct(out_funct),
        .out_zero(out_zero), .out_neg(out_neg),
`ifdef RESULT_PARITY_EN
        .out_parity(out_parity),
`endif
        .res_count(res_count)
    );

    alu_result_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_res(in_res), .in_funct(in_funct), .out_valid(out_valid4),
        .out_ready(out_ready), .out_res(out_res4), .out_funct(out_funct4),
        .out_zero(out_zero4), .out_neg(out_neg4),
`ifdef RESULT_PARITY_EN
        .out_parity(out_parity4),
`endif
        .res_count(res_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model: queue of {funct, res}, delivered-count for both widths.
    logic [34:0] mq[$];
    int unsigned cnt16 = 0;
    int unsigned cnt4 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic        v;
        logic [34:0] h;
        v = (mq.size() > 0);
        h = v ? mq[0] : '0;
        check("out_valid", out_valid, v);
        check("in_ready", in_ready, mq.size() < 2);
        check("out_res", out_res, h[31:0]);
        check("out_funct", out_funct, h[34:32]);
        check("out_zero", out_zero, v && (h[31:0] == 32'd0));
        check("out_neg", out_neg, v && h[31]);
`ifdef RESULT_PARITY_EN
        check("out_parity", out_parity, v && (^h[31:0]));
`endif
        check("res_count", res_count, cnt16);
        check("res_count4", res_count4, cnt4);
        check("out_valid4", out_valid4, v);
        check("out_res4", out_res4, h[31:0]);
    endtask

    task automatic model_clear();
        mq.delete();
        cnt16 = 0;
        cnt4 = 0;
    endtask

    // One clock: decide push/pop from the model, advance, update model, compare.
    task automatic cycle(output bit pushed, output bit popped, output logic [31:0] pres);
        bit do_pop, do_push;
        do_pop  = (mq.size() > 0) && out_ready;
        do_push = in_valid && (mq.size() < 2);
        pres    = out_res;
        @(posedge clk);
        #1;
        if (do_pop) begin
            void'(mq.pop_front());
            if (cnt16 < 65535) cnt16++;
            if (cnt4 < 15) cnt4++;
        end
        if (do_push) mq.push_back({in_funct, in_res});
        pushed = do_push;
        popped = do_pop;
        check_outputs();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_clear();
        check_outputs();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] ires;
        logic [2:0]  ifn;
        logic        ordy;
        logic        ev;
        logic        erdy;
        logic [31:0] eres;
        logic [2:0]  efn;
        logic        ez;
        logic        en;
        logic        ep;
        int unsigned ecnt;
    } vec_t;

    vec_t        tbl [8];
    bit          pu, po;
    logic [31:0] pr;
    logic [31:0] sent [10];
    logic [31:0] got[$];
    int unsigned k;
    int unsigned pops;

    initial begin
        tbl[0] = '{1'b1, 32'h0000_0000, 3'd1, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 3'd1, 1'b1, 1'b0, 1'b0, 0};
        tbl[1] = '{1'b0, 32'h0000_0000, 3'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 3'd0, 1'b0, 1'b0, 1'b0, 1};
        tbl[2] = '{1'b1, 32'h8000_0001, 3'd2, 1'b0, 1'b1, 1'b1, 32'h8000_0001, 3'd2, 1'b0, 1'b1, 1'b0, 1};
        tbl[3] = '{1'b1, 32'h0000_00FF, 3'd3, 1'b0, 1'b1, 1'b0, 32'h8000_0001, 3'd2, 1'b0, 1'b1, 1'b0, 1};
        tbl[4] = '{1'b1, 32'hDEAD_BEEF, 3'd4, 1'b0, 1'b1, 1'b0, 32'h8000_0001, 3'd2, 1'b0, 1'b1, 1'b0, 1};
        tbl[5] = '{1'b0, 32'h0000_0000, 3'd0, 1'b1, 1'b1, 1'b1, 32'h0000_00FF, 3'd3, 1'b0, 1'b0, 1'b0, 2};
        tbl[6] = '{1'b1, 32'h1234_5678, 3'd5, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 3'd5, 1'b0, 1'b0, 1'b1, 3};
        tbl[7] = '{1'b0, 32'h0000_0000, 3'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 3'd0, 1'b0, 1'b0, 1'b0, 4};

        rst = 1'b0;
        in_valid = 1'b0;
        in_res = '0;
        in_funct = '0;
        out_ready = 1'b0;
        #1;
        do_reset();

        // Directed table: zero result, back-pressure to full, push+pop at occupancy 1.
        for (int i = 0; i < 8; i++) begin
            in_valid  = tbl[i].iv;
            in_res    = tbl[i].ires;
            in_funct  = tbl[i].ifn;
            out_ready = tbl[i].ordy;
            cycle(pu, po, pr);
            check($sformatf("tbl%0d_flags", i),
                  {out_valid, in_ready, out_res, out_funct, out_zero, out_neg},
                  {tbl[i].ev, tbl[i].erdy, tbl[i].eres, tbl[i].efn, tbl[i].ez, tbl[i].en});
            check($sformatf("tbl%0d_count", i), res_count, tbl[i].ecnt);
`ifdef RESULT_PARITY_EN
            check($sformatf("tbl%0d_parity", i), out_parity, tbl[i].ep);
`endif
        end

        // Fill the FIFO, then assert reset between clock edges.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_res    = 32'hA5A5_0001; in_funct = 3'd6;
        cycle(pu, po, pr);
        in_res    = 32'hA5A5_0002; in_funct = 3'd7;
        cycle(pu, po, pr);
        in_valid  = 1'b0;
        check("full_before_rst", in_ready, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_valid", out_valid, 1'b0);
        check("rst_async_ready", in_ready, 1'b1);
        check("rst_async_count", res_count, 0);
        check("rst_async_res", out_res, 0);
        model_clear();
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Ten results with out_ready toggling each cycle: order and count.
        foreach (sent[i]) sent[i] = $urandom;
        k = 0;
        got.delete();
        for (int c = 0; c < 100 && got.size() < 10; c++) begin
            in_valid  = (k < 10);
            in_res    = (k < 10) ? sent[k] : 32'd0;
            in_funct  = 3'(k);
            out_ready = ~out_ready;
            cycle(pu, po, pr);
            if (pu) k++;
            if (po) got.push_back(pr);
        end
        in_valid = 1'b0;
        check("stream_delivered", got.size(), 10);
        foreach (got[i]) check($sformatf("stream_order%0d", i), got[i], sent[i]);
        check("stream_count", res_count, 10);

        // Randomized traffic after a fresh reset; narrow counter must saturate.
        do_reset();
        pops = 0;
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            case ($urandom_range(4))
                0:       in_res = 32'd0;
                1:       in_res = 32'h8000_0000;
                default: in_res = $urandom;
            endcase
            in_funct = 3'($urandom_range(7));
            cycle(pu, po, pr);
            if (po) pops++;
        end
        check("rand_enough_pops", pops >= 20, 1'b1);
        check("sat4", res_count4, 15);
        check("count16", res_count, pops);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
